// File: rtl/mult_share_if.sv
// Request/response bundle between datapath requesters and mult_share_ctrl.
// The master side presents operands and consumes results; the slave side is the controller.
interface mult_share_if #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [15:0]       rsp_prod;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_prod
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_prod
   );
endinterface

// File: rtl/mult_share_ctrl.sv
// Time-shares one external combinational 8x8 multiplier among NREQ requesters with
// round-robin arbitration and an id-tagged valid/ready response channel.
module mult_share_ctrl #(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   mult_share_if.slave      bus,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   input  logic [15:0]      mul_prod,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   id_reg;
   logic [ID_W-1:0]   grant_id;
   logic [ID_W-1:0]   rr_ptr_nxt;
   logic [NREQ-1:0]   hi_mask;
   logic [NREQ-1:0]   masked_valid;
   logic [NREQ-1:0]   grant_onehot;
   logic [7:0]        sel_a;
   logic [7:0]        sel_b;
   logic              any_valid;
   logic              accept;
   logic              complete;

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("mult_share_ctrl: NREQ must be in 2..8");
   end
   if (ID_W != $clog2(NREQ)) begin : g_bad_id_w
      $error("mult_share_ctrl: ID_W must equal clog2(NREQ)");
   end

   function automatic logic [ID_W-1:0] lowest_set(input logic [NREQ-1:0] v);
      logic [ID_W-1:0] r;
      r = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (v[i]) r = ID_W'(i);
      end
      return r;
   endfunction

   // Search from rr_ptr upward first; fall back to the lowest index when nothing sits above it.
   assign hi_mask      = ~((NREQ'(1) << rr_ptr) - NREQ'(1));
   assign masked_valid = bus.req_valid & hi_mask;
   assign any_valid    = |bus.req_valid;
   assign grant_id     = (|masked_valid) ? lowest_set(masked_valid) : lowest_set(bus.req_valid);
   assign grant_onehot = NREQ'(1) << grant_id;
   assign rr_ptr_nxt   = (id_reg == ID_W'(NREQ - 1)) ? '0 : id_reg + 1'b1;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_a = bus.req_a[8*i +: 8];
            sel_b = bus.req_b[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first so no branch can infer a latch.
      state_nxt     = state;
      accept        = 1'b0;
      complete      = 1'b0;
      bus.req_ready = '0;
      unique case (state)
         IDLE: begin
            if (any_valid && !rst) begin
               bus.req_ready = grant_onehot;
               accept        = 1'b1;
               state_nxt     = MUL;
            end
         end
         MUL: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_a        <= '0;
         mul_b        <= '0;
         id_reg       <= '0;
         rr_ptr       <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_prod  <= '0;
         op_count     <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register here update together at the edge.
         if (accept) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            id_reg <= grant_id;
         end
         if (state == MUL) begin
            bus.rsp_prod  <= mul_prod;
            bus.rsp_id    <= id_reg;
            bus.rsp_valid <= 1'b1;
         end
         if (complete) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= rr_ptr_nxt;
            if (op_count != '1) op_count <= op_count + 1'b1;
         end
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(bus.req_ready));

   a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
      (bus.req_ready != '0) |-> (state == IDLE));

   a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.rsp_valid && !bus.rsp_ready) |=>
         (bus.rsp_valid && $stable(bus.rsp_id) && $stable(bus.rsp_prod)));

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: one NREQ=4 instance with a 16-bit counter and a
// twin with a 2-bit counter fed the same stimulus to exercise saturation.
module tb_mult_share_ctrl;
   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_share_if #(.NREQ(NREQ), .ID_W(ID_W)) bus_m ();
   mult_share_if #(.NREQ(NREQ), .ID_W(ID_W)) bus_s ();

   logic [7:0]  mul_a, mul_b, sat_mul_a, sat_mul_b;
   logic [15:0] mul_prod, sat_mul_prod;
   logic        busy, sat_busy;
   logic [15:0] op_count;
   logic [1:0]  sat_op_count;

   // Stand-ins for the external mult_8b instances.
   assign mul_prod     = 16'(mul_a) * 16'(mul_b);
   assign sat_mul_prod = 16'(sat_mul_a) * 16'(sat_mul_b);

   assign bus_s.req_valid = bus_m.req_valid;
   assign bus_s.req_a     = bus_m.req_a;
   assign bus_s.req_b     = bus_m.req_b;
   assign bus_s.rsp_ready = bus_m.rsp_ready;

   mult_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_m.slave),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_prod (mul_prod),
      .busy     (busy),
      .op_count (op_count)
   );

   mult_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(2)) dut_sat (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_s.slave),
      .mul_a    (sat_mul_a),
      .mul_b    (sat_mul_b),
      .mul_prod (sat_mul_prod),
      .busy     (sat_busy),
      .op_count (sat_op_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_rsp(input string tag);
      int i;
      i = 0;
      while (!bus_m.rsp_valid && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (!bus_m.rsp_valid) check({tag, "_timeout"}, 32'(bus_m.rsp_valid), 32'd1);
   endtask

   task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input string tag);
      @(negedge clk);
      bus_m.req_a[8*id +: 8] = a;
      bus_m.req_b[8*id +: 8] = b;
      bus_m.req_valid        = 4'(1 << id);
      bus_m.rsp_ready        = 1'b1;
      wait_rsp(tag);
      check({tag, "_id"},   32'(bus_m.rsp_id),   32'(id));
      check({tag, "_prod"}, 32'(bus_m.rsp_prod), 32'(exp));
      bus_m.req_valid = '0;
      @(negedge clk);
      check({tag, "_done"}, 32'(bus_m.rsp_valid), 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int got_n;
      int last_c;
      logic [1:0]  t2_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [15:0] t2_prod [5] = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd2};

      rst             = 1'b1;
      bus_m.req_valid = '0;
      bus_m.req_a     = '0;
      bus_m.req_b     = '0;
      bus_m.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_ready",    32'(bus_m.req_ready), 32'd0);
      check("rst_rsp_vld",  32'(bus_m.rsp_valid), 32'd0);
      check("rst_rsp_id",   32'(bus_m.rsp_id),    32'd0);
      check("rst_rsp_prod", 32'(bus_m.rsp_prod),  32'd0);
      check("rst_mul_a",    32'(mul_a),           32'd0);
      check("rst_busy",     32'(busy),            32'd0);
      check("rst_count",    32'(op_count),        32'd0);
      rst = 1'b0;

      // 1: single request
      @(negedge clk);
      bus_m.req_a[7:0] = 8'd12;
      bus_m.req_b[7:0] = 8'd13;
      bus_m.req_valid  = 4'b0001;
      #1;
      check("t1_ready", 32'(bus_m.req_ready), 32'b0001);
      check("t1_idle",  32'(busy),            32'd0);
      @(negedge clk);
      bus_m.req_valid = '0;
      #1;
      check("t1_ready_mul", 32'(bus_m.req_ready), 32'd0);
      check("t1_busy",      32'(busy),            32'd1);
      check("t1_mul_a",     32'(mul_a),           32'd12);
      check("t1_mul_b",     32'(mul_b),           32'd13);
      check("t1_no_rsp",    32'(bus_m.rsp_valid), 32'd0);
      @(negedge clk);
      check("t1_rsp_vld",  32'(bus_m.rsp_valid), 32'd1);
      check("t1_rsp_id",   32'(bus_m.rsp_id),    32'd0);
      check("t1_rsp_prod", 32'(bus_m.rsp_prod),  32'd156);
      bus_m.rsp_ready = 1'b1;
      @(negedge clk);
      check("t1_done",      32'(bus_m.rsp_valid), 32'd0);
      check("t1_count",     32'(op_count),        32'd1);
      check("t1_sat_count", 32'(sat_op_count),    32'd1);
      check("t1_busy_end",  32'(busy),            32'd0);
      bus_m.rsp_ready = 1'b0;

      // 2: all four requesting continuously from reset
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         bus_m.req_a[8*i +: 8] = 8'(i + 1);
         bus_m.req_b[8*i +: 8] = 8'(i + 2);
      end
      bus_m.req_valid = 4'b1111;
      bus_m.rsp_ready = 1'b1;
      #1;
      check("t2_ready_in_rst", 32'(bus_m.req_ready), 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      got_n  = 0;
      last_c = 0;
      for (int c = 0; c < 40 && got_n < 5; c++) begin
         @(negedge clk);
         if (bus_m.rsp_valid) begin
            check($sformatf("t2_id%0d", got_n),   32'(bus_m.rsp_id),   32'(t2_id[got_n]));
            check($sformatf("t2_prod%0d", got_n), 32'(bus_m.rsp_prod), 32'(t2_prod[got_n]));
            if (got_n > 0) check($sformatf("t2_gap%0d", got_n), 32'(c - last_c), 32'd3);
            last_c = c;
            got_n++;
            if (got_n == 5) bus_m.req_valid = '0;
         end
      end
      if (got_n < 5) check("t2_rsp_count", 32'(got_n), 32'd5);
      @(negedge clk);
      check("t2_count",     32'(op_count),     32'd5);
      check("t2_sat_count", 32'(sat_op_count), 32'd3);
      check("t2_idle",      32'(busy),         32'd0);

      // 3: boundary operands
      single_op(1, 8'd255, 8'd255, 16'hFE01, "t3_max");
      single_op(2, 8'd0,   8'd200, 16'd0,    "t3_zero");
      single_op(3, 8'd1,   8'd255, 16'd255,  "t3_one");

      // 4: backpressure with another request pending
      @(negedge clk);
      bus_m.rsp_ready  = 1'b0;
      bus_m.req_a[7:0]   = 8'd7;
      bus_m.req_b[7:0]   = 8'd9;
      bus_m.req_a[23:16] = 8'd10;
      bus_m.req_b[23:16] = 8'd11;
      bus_m.req_valid    = 4'b0101;
      #1;
      check("t4_ready", 32'(bus_m.req_ready), 32'b0001);
      wait_rsp("t4");
      check("t4_id",   32'(bus_m.rsp_id),   32'd0);
      check("t4_prod", 32'(bus_m.rsp_prod), 32'd63);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("t4_hold",
               32'({bus_m.rsp_valid, bus_m.rsp_id, bus_m.rsp_prod, bus_m.req_ready}),
               32'({1'b1, 2'd0, 16'd63, 4'd0}));
      end
      bus_m.rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_done",       32'(bus_m.rsp_valid), 32'd0);
      check("t4_next_grant", 32'(bus_m.req_ready), 32'b0100);
      wait_rsp("t4b");
      check("t4b_id",   32'(bus_m.rsp_id),   32'd2);
      check("t4b_prod", 32'(bus_m.rsp_prod), 32'd110);
      bus_m.req_valid = '0;
      @(negedge clk);
      check("t4_count",     32'(op_count),     32'd10);
      check("t4_sat_count", 32'(sat_op_count), 32'd3);

      // 5: asynchronous reset while requester 2 is in MUL
      @(negedge clk);
      bus_m.rsp_ready    = 1'b0;
      bus_m.req_a[23:16] = 8'd50;
      bus_m.req_b[23:16] = 8'd5;
      bus_m.req_valid    = 4'b0100;
      @(negedge clk);
      check("t5_busy_mul", 32'(busy),  32'd1);
      check("t5_mul_a",    32'(mul_a), 32'd50);
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_vld",   32'(bus_m.rsp_valid), 32'd0);
      check("t5_rst_busy",  32'(busy),            32'd0);
      check("t5_rst_count", 32'(op_count),        32'd0);
      check("t5_rst_sat",   32'(sat_op_count),    32'd0);
      check("t5_rst_mul_a", 32'(mul_a),           32'd0);
      check("t5_rst_ready", 32'(bus_m.req_ready), 32'd0);
      bus_m.req_a[23:16] = 8'd9;
      bus_m.req_b[23:16] = 8'd9;
      bus_m.req_a[31:24] = 8'd6;
      bus_m.req_b[31:24] = 8'd6;
      bus_m.req_valid    = 4'b1100;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t5_first_grant", 32'(bus_m.req_ready), 32'b0100);
      wait_rsp("t5");
      check("t5_id",   32'(bus_m.rsp_id),   32'd2);
      check("t5_prod", 32'(bus_m.rsp_prod), 32'd81);
      bus_m.req_valid = '0;
      bus_m.rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_done",  32'(bus_m.rsp_valid), 32'd0);
      check("t5_count", 32'(op_count),        32'd1);

      // 6: operands change after acceptance
      @(negedge clk);
      bus_m.req_a[15:8] = 8'd20;
      bus_m.req_b[15:8] = 8'd3;
      bus_m.req_valid   = 4'b0010;
      @(negedge clk);
      bus_m.req_a[15:8] = 8'd99;
      bus_m.req_b[15:8] = 8'd99;
      check("t6_mul_a", 32'(mul_a), 32'd20);
      check("t6_mul_b", 32'(mul_b), 32'd3);
      wait_rsp("t6");
      check("t6_id",   32'(bus_m.rsp_id),   32'd1);
      check("t6_prod", 32'(bus_m.rsp_prod), 32'd60);
      bus_m.req_valid = '0;
      @(negedge clk);
      check("t6_count",     32'(op_count),     32'd2);
      check("t6_sat_count", 32'(sat_op_count), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
